// File: rtl/arm_mc_controller.sv
// ---------------------------------------------------------------------------
// arm_mc_controller
//
// Control unit for the multicycle ARM core. It holds the main FSM, the ALU
// decoder, the condition-check logic, the NZCV flags register and the
// registered condition-pass bit. It drives every datapath select/enable.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   Instr      in   [31:0] latched instruction (IR output)
//   ALUFlags   in   [3:0]  {N,Z,C,V} from the ALU, combinational
//   PCWrite    out  PC register enable
//   RegWrite   out  register-file write enable
//   MemWrite   out  data-memory write strobe
//   IRWrite    out  instruction register enable
//   AdrSrc     out  0 = PC, 1 = Result as memory address
//   RegSrc     out  [1:0] [0] selects R15 for RA1, [1] selects Rd for RA2
//   ALUSrcA    out  [1:0] 00 = A reg, 01 = PC
//   ALUSrcB    out  [1:0] 00 = WriteData, 01 = ExtImm, 10 = constant 4
//   ResultSrc  out  [1:0] 00 = ALUOut, 01 = Data, 10 = ALUResult
//   ImmSrc     out  [1:0] 00 = imm8, 01 = imm12, 10 = branch imm24
//   ALUControl out  [2:0] 000 ADD, 001 SUB, 010 AND, 011 ORR
//   State      out  [3:0] current FSM state (debug)
//
// Parameter FETCH_ONLY_UNDEF: 1 -> Op=11 goes DECODE->FETCH with no side
// effects; 0 -> Op=11 parks the FSM in UNKNOWN until reset.
//
// Optional feature macro CTRL_CMP_EN: when defined, cmd 1010 with S=1 (CMP)
// decodes as a flag-setting SUB with no register write-back.
// ---------------------------------------------------------------------------
module arm_mc_controller #(
  parameter bit FETCH_ONLY_UNDEF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  flags_r;
  logic        cond_ok_r;

  logic [1:0]  op_s;
  logic [5:0]  funct_s;
  logic [3:0]  rd_s;
  logic [3:0]  cond_s;
  logic [3:0]  cmd_s;
  logic        s_bit_s;
  logic        rd_pc_s;
  logic        unused_bits_s;

  logic [2:0]  dp_alu_s;
  logic        dp_wr_s;
  logic        dp_flag_s;
  logic        dp_cv_s;

  logic        pc_write_s;
  logic        reg_write_s;
  logic        mem_write_s;
  logic        ir_write_s;

  assign op_s    = Instr[27:26];
  assign funct_s = Instr[25:20];
  assign rd_s    = Instr[15:12];
  assign cond_s  = Instr[31:28];
  assign cmd_s   = funct_s[4:1];
  assign s_bit_s = funct_s[0];
  assign rd_pc_s = (rd_s == 4'd15);

  // Register-number and immediate fields are consumed by the datapath only.
  assign unused_bits_s = ^{Instr[19:16], Instr[11:0]};

  // Condition evaluation over {N,Z,C,V}; code 1111 never passes.
  function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Condition-pass bit, sampled once per instruction in DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_ok_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      cond_ok_r <= cond_ex(cond_s, flags_r);
    end
  end

  // NZCV register: written on the edge leaving an execute state. C/V hold
  // for logical ops, which do not produce meaningful carry/overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r <= 4'b0000;
    end else if (((state_r == S_EXECUTER) || (state_r == S_EXECUTEI)) &&
                 cond_ok_r && s_bit_s && dp_flag_s) begin
      flags_r[3:2] <= ALUFlags[3:2];
      if (dp_cv_s) begin
        flags_r[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // ALU decoder for data-processing commands.
  always_comb begin
    dp_alu_s  = ALU_ADD;
    dp_wr_s   = 1'b0;
    dp_flag_s = 1'b0;
    dp_cv_s   = 1'b0;
    case (cmd_s)
      4'b0100: begin dp_alu_s = ALU_ADD; dp_wr_s = 1'b1; dp_flag_s = 1'b1; dp_cv_s = 1'b1; end
      4'b0010: begin dp_alu_s = ALU_SUB; dp_wr_s = 1'b1; dp_flag_s = 1'b1; dp_cv_s = 1'b1; end
      4'b0000: begin dp_alu_s = ALU_AND; dp_wr_s = 1'b1; dp_flag_s = 1'b1; dp_cv_s = 1'b0; end
      4'b1100: begin dp_alu_s = ALU_ORR; dp_wr_s = 1'b1; dp_flag_s = 1'b1; dp_cv_s = 1'b0; end
`ifdef CTRL_CMP_EN
      4'b1010: begin
        // CMP only exists in its flag-setting form; without S it is unsupported.
        if (s_bit_s) begin
          dp_alu_s  = ALU_SUB;
          dp_flag_s = 1'b1;
          dp_cv_s   = 1'b1;
        end else begin
          dp_alu_s  = ALU_ADD;
          dp_flag_s = 1'b0;
          dp_cv_s   = 1'b0;
        end
      end
`endif
      default: begin dp_alu_s = ALU_ADD; dp_wr_s = 1'b0; dp_flag_s = 1'b0; dp_cv_s = 1'b0; end
    endcase
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_next_s = S_FETCH;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUControl   = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        state_next_s = S_DECODE;
      end
      S_DECODE: begin
        // PC+4 again so that R15 reads PC+8.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        case (op_s)
          2'b01:   state_next_s = S_MEMADR;
          2'b00:   state_next_s = funct_s[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_next_s = S_BRANCH;
          default: state_next_s = FETCH_ONLY_UNDEF ? S_FETCH : S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB      = 2'b01;
        ALUControl   = funct_s[3] ? ALU_ADD : ALU_SUB;
        state_next_s = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc       = 1'b1;
        state_next_s = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        reg_write_s  = cond_ok_r;
        pc_write_s   = cond_ok_r & rd_pc_s;
        state_next_s = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        mem_write_s  = cond_ok_r;
        state_next_s = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcB      = 2'b00;
        ALUControl   = dp_alu_s;
        state_next_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB      = 2'b01;
        ALUControl   = dp_alu_s;
        state_next_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = cond_ok_r & dp_wr_s;
        pc_write_s   = cond_ok_r & dp_wr_s & rd_pc_s;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB      = 2'b01;
        ResultSrc    = 2'b10;
        pc_write_s   = cond_ok_r;
        state_next_s = S_FETCH;
      end
      S_UNKNOWN: begin
        state_next_s = S_UNKNOWN;
      end
      default: begin
        // Unused encodings recover through FETCH.
        state_next_s = S_FETCH;
      end
    endcase
  end

  // Op-only decodes, valid in every state.
  always_comb begin
    RegSrc = {(op_s == 2'b01), (op_s == 2'b10)};
    case (op_s)
      2'b00:   ImmSrc = 2'b00;
      2'b01:   ImmSrc = 2'b01;
      2'b10:   ImmSrc = 2'b10;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Enables are gated by reset directly so a mid-instruction reset
  // kills any write in flight without waiting for a clock.
  assign PCWrite  = pc_write_s  & reset;
  assign RegWrite = reg_write_s & reset;
  assign MemWrite = mem_write_s & reset;
  assign IRWrite  = ir_write_s  & reset;
  assign State    = state_r;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed testbench for arm_mc_controller. A second instance with
// FETCH_ONLY_UNDEF=0 shares all inputs to observe the UNKNOWN hold.
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;

  logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  logic        u_PCWrite, u_RegWrite, u_MemWrite, u_IRWrite, u_AdrSrc;
  logic [1:0]  u_RegSrc, u_ALUSrcA, u_ALUSrcB, u_ResultSrc, u_ImmSrc;
  logic [2:0]  u_ALUControl;
  logic [3:0]  u_State;

  int n_pass = 0;
  int n_tot  = 0;

`ifdef CTRL_CMP_EN
  localparam logic [2:0] CMP_ALU   = 3'b001;
  localparam logic       CMP_TAKEN = 1'b1;
`else
  localparam logic [2:0] CMP_ALU   = 3'b000;
  localparam logic       CMP_TAKEN = 1'b0;
`endif

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
  );

  arm_mc_controller #(.FETCH_ONLY_UNDEF(1'b0)) dut_u (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(u_PCWrite), .RegWrite(u_RegWrite), .MemWrite(u_MemWrite), .IRWrite(u_IRWrite),
    .AdrSrc(u_AdrSrc), .RegSrc(u_RegSrc), .ALUSrcA(u_ALUSrcA), .ALUSrcB(u_ALUSrcB),
    .ResultSrc(u_ResultSrc), .ImmSrc(u_ImmSrc), .ALUControl(u_ALUControl), .State(u_State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ins);
    Instr = ins;
    #1;
  endtask

  // Data-processing instruction from FETCH back to FETCH.
  task automatic dp(input string tag, input logic [31:0] ins, input logic [3:0] fl,
                    input logic [3:0] ex_st, input logic [2:0] ex_alu,
                    input logic ex_regw, input logic ex_pcw);
    load(ins);
    tick(); chk({tag, "_dec"}, State, 4'd1);
    tick(); chk({tag, "_exst"}, State, ex_st);
    chk({tag, "_alu"}, ALUControl, ex_alu);
    chk({tag, "_ex_regw"}, RegWrite, 1'b0);
    ALUFlags = fl;
    tick(); chk({tag, "_wbst"}, State, 4'd8);
    ALUFlags = 4'b0000;
    chk({tag, "_regw"}, RegWrite, ex_regw);
    chk({tag, "_pcw"}, PCWrite, ex_pcw);
    tick(); chk({tag, "_fetch"}, State, 4'd0);
  endtask

  // Branch from FETCH back to FETCH, checking whether it is taken.
  task automatic br(input string tag, input logic [31:0] ins, input logic ex_pcw);
    load(ins);
    tick();
    tick(); chk({tag, "_st"}, State, 4'd9);
    chk({tag, "_pcw"}, PCWrite, ex_pcw);
    tick(); chk({tag, "_fetch"}, State, 4'd0);
  endtask

  initial begin
    reset = 1'b1; Instr = 32'hE2821005; ALUFlags = 4'b0000;
    #2 reset = 1'b0;
    #1;
    chk("rst_state", State, 4'd0);
    chk("rst_pcw", PCWrite, 1'b0);
    chk("rst_irw", IRWrite, 1'b0);
    chk("rst_regw", RegWrite, 1'b0);
    chk("rst_memw", MemWrite, 1'b0);
    tick(); tick();
    chk("rst_hold", State, 4'd0);
    reset = 1'b1;
    #1;
    // ADD R1,R2,#5
    chk("f_pcw", PCWrite, 1'b1);
    chk("f_irw", IRWrite, 1'b1);
    chk("f_srca", ALUSrcA, 2'b01);
    chk("f_srcb", ALUSrcB, 2'b10);
    chk("f_res", ResultSrc, 2'b10);
    tick(); chk("add_dec", State, 4'd1);
    chk("add_dec_pcw", PCWrite, 1'b0);
    chk("add_dec_srcb", ALUSrcB, 2'b10);
    tick(); chk("add_exi", State, 4'd7);
    chk("add_exi_srcb", ALUSrcB, 2'b01);
    chk("add_exi_regw", RegWrite, 1'b0);
    tick(); chk("add_wb", State, 4'd8);
    chk("add_wb_regw", RegWrite, 1'b1);
    chk("add_wb_pcw", PCWrite, 1'b0);
    tick(); chk("add_fetch", State, 4'd0);

    // LDR
    load(32'hE5910004);
    chk("ldr_immsrc", ImmSrc, 2'b01);
    tick(); chk("ldr_dec", State, 4'd1);
    tick(); chk("ldr_adr", State, 4'd2);
    chk("ldr_adr_alu", ALUControl, 3'b000);
    chk("ldr_adr_srcb", ALUSrcB, 2'b01);
    tick(); chk("ldr_rd", State, 4'd3);
    chk("ldr_rd_adrsrc", AdrSrc, 1'b1);
    tick(); chk("ldr_wb", State, 4'd4);
    chk("ldr_wb_res", ResultSrc, 2'b01);
    chk("ldr_wb_regw", RegWrite, 1'b1);
    chk("ldr_wb_pcw", PCWrite, 1'b0);
    tick(); chk("ldr_fetch", State, 4'd0);

    // STR
    load(32'hE5810004);
    chk("str_regsrc", RegSrc, 2'b10);
    tick(); tick();
    tick(); chk("str_wr", State, 4'd5);
    chk("str_memw", MemWrite, 1'b1);
    chk("str_adrsrc", AdrSrc, 1'b1);
    tick(); chk("str_fetch", State, 4'd0);
    chk("str_memw_off", MemWrite, 1'b0);

    // SUBS with Z=1, then conditional branches and a failed ADDNE
    dp("subs_z", 32'hE0500000, 4'b0100, 4'd6, 3'b001, 1'b1, 1'b0);
    load(32'h0A000002);
    chk("beq_immsrc", ImmSrc, 2'b10);
    chk("beq_regsrc", RegSrc, 2'b01);
    tick();
    tick(); chk("beq_st", State, 4'd9);
    chk("beq_pcw", PCWrite, 1'b1);
    chk("beq_srcb", ALUSrcB, 2'b01);
    chk("beq_res", ResultSrc, 2'b10);
    tick();
    br("bne", 32'h1A000002, 1'b0);
    dp("addne", 32'h12811001, 4'b0000, 4'd7, 3'b000, 1'b0, 1'b0);
    br("beq2", 32'h0A000002, 1'b1);

    // Op=11
    load(32'hEC000000);
    tick(); chk("undef_dec", State, 4'd1);
    chk("undef_pcw", PCWrite, 1'b0);
    chk("undef_regw", RegWrite, 1'b0);
    chk("undef_memw", MemWrite, 1'b0);
    chk("undef_irw", IRWrite, 1'b0);
    tick(); chk("undef_fetch", State, 4'd0);
    chk("u_state", u_State, 4'd15);
    chk("u_pcw", u_PCWrite, 1'b0);
    chk("u_irw", u_IRWrite, 1'b0);

    // C/V hold across logical ops
    dp("subs_cv", 32'hE0500000, 4'b0011, 4'd6, 3'b001, 1'b1, 1'b0);
    dp("ands", 32'hE0100000, 4'b1000, 4'd6, 3'b010, 1'b1, 1'b0);
    br("bge", 32'hAA000002, 1'b1);
    br("bcs", 32'h2A000002, 1'b1);
    dp("orrs", 32'hE1900000, 4'b0110, 4'd6, 3'b011, 1'b1, 1'b0);
    br("bhi", 32'h8A000002, 1'b0);
    br("bvs", 32'h6A000002, 1'b1);
    chk("u_hold", u_State, 4'd15);

    // Unsupported cmd (EORS): no write-back, flags untouched
    dp("eors", 32'hE0300000, 4'b0000, 4'd6, 3'b000, 1'b0, 1'b0);
    br("beq3", 32'h0A000002, 1'b1);

    // Writes to R15
    dp("addpc", 32'hE282F005, 4'b0000, 4'd7, 3'b000, 1'b1, 1'b1);
    load(32'hE591F004);
    tick(); tick(); tick();
    tick(); chk("ldrpc_wb", State, 4'd4);
    chk("ldrpc_pcw", PCWrite, 1'b1);
    tick();

    // CMP R0,#0
    dp("subs_clr", 32'hE0500000, 4'b0000, 4'd6, 3'b001, 1'b1, 1'b0);
    dp("cmp", 32'hE3500000, 4'b0100, 4'd7, CMP_ALU, 1'b0, 1'b0);
    br("beq_cmp", 32'h0A000002, CMP_TAKEN);

    // Reset in the middle of a store
    load(32'hE5810004);
    tick(); tick();
    tick(); chk("rstw_st", State, 4'd5);
    chk("rstw_memw", MemWrite, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstw_memw_off", MemWrite, 1'b0);
    chk("rstw_state", State, 4'd0);
    chk("rstw_u_state", u_State, 4'd0);
    tick();
    reset = 1'b1;
    Instr = 32'h0A000002;
    #1;
    chk("rel_pcw", PCWrite, 1'b1);
    tick();
    tick(); chk("rel_beq_st", State, 4'd9);
    chk("rel_beq_pcw", PCWrite, 1'b0);
    tick(); chk("rel_fetch", State, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
Control unit for the multicycle ARM core. It drives every select and enable on the datapath and the memory write strobe. Inputs are the latched Instr and the combinational ALUFlags; all control outputs come back to the datapath. It contains the main FSM, the ALU decoder, the condition-check logic, the NZCV flags register and the registered condition-pass bit.

Parameters:
FETCH_ONLY_UNDEF, 1, 1: Op=2'b11 returns DECODE->FETCH with no side effects; 0: FSM enters UNKNOWN state and holds there until reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
Instr  in  32  current instruction (IR output)
ALUFlags  in  4  {N,Z,C,V} from ALU, combinational
PCWrite  out  1  PC register enable
RegWrite  out  1  register-file write enable
MemWrite  out  1  data memory write strobe
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0=PC, 1=Result as memory address
RegSrc  out  2  [0]=1 selects R15 for RA1; [1]=1 selects Rd for RA2
ALUSrcA  out  2  00=A reg, 01=PC
ALUSrcB  out  2  00=WriteData reg, 01=ExtImm, 10=const 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  out  2  00=imm8, 01=imm12, 10=branch imm24
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
State  out  4  current FSM state (debug)

Behaviour:
- Reset low: State=FETCH, Flags=0000, cond_ok=0. PCWrite, RegWrite, MemWrite and IRWrite are forced 0 combinationally while reset is low, including a reset asserted mid-instruction. The first FETCH occurs on the first edge after release.
- Field use: Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12], Cond=Instr[31:28].
- RegSrc and ImmSrc decode from Op in every state. RegSrc={Op==01, Op==10}. ImmSrc=00 for data processing, 01 for memory, 10 for branch.
- Defaults, unless a state overrides: ALUSrcA=00, ALUSrcB=00, ResultSrc=00, AdrSrc=0, ALUControl=ADD, all enables 0.
- State encodings and transitions:
  - FETCH(0): IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1 -> DECODE.
  - DECODE(1): ALUSrcA=01, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8). Latch cond_ok=CondEx(Cond,Flags).
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=1 -> EXECUTEI; with Funct[5]=0 -> EXECUTER.
    - Op=10 -> BRANCH.
    - Op=11 -> per FETCH_ONLY_UNDEF.
  - MEMADR(2): ALUSrcB=01; ALUControl=ADD if U (Funct[3])=1, else SUB. Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD(3): AdrSrc=1 -> MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=cond_ok, PCWrite=cond_ok&(Rd==15) -> FETCH.
  - MEMWRITE(5): AdrSrc=1, MemWrite=cond_ok -> FETCH.
  - EXECUTER(6): ALUSrcB=00 -> ALUWB.
  - EXECUTEI(7): ALUSrcB=01 -> ALUWB.
  - ALUWB(8): RegWrite=cond_ok&dp_wr, PCWrite=cond_ok&dp_wr&(Rd==15) -> FETCH.
  - BRANCH(9): ALUSrcB=01, ResultSrc=10, PCWrite=cond_ok -> FETCH.
  - UNKNOWN(15): all enables 0; exits only via reset.
- ALU decoder (EXECUTER/EXECUTEI), cmd=Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR: dp_wr=1.
  - Any other cmd: ALUControl=ADD, dp_wr=0, no flag write.
- Flags register: written on the clock edge leaving EXECUTER/EXECUTEI, only if cond_ok & S (Funct[0]) & cmd supported.
  - NZ always update.
  - CV update only for ADD/SUB; they hold for AND/ORR.
- CondEx covers all 16 codes:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 = 0.
- Latency (cycles): data processing 4, load 5, store 4, branch 3. A failed condition keeps the same cycle count with writes suppressed; FETCH still writes PC+4.

Optional Feature:
CTRL_CMP_EN
- Defined: cmd 1010 (CMP) with S=1 decodes as SUB, dp_wr=0, flags update per the SUB rule. Cmd 1010 with S=0 behaves as an unsupported cmd.
- Undefined: cmd 1010 behaves as an unsupported cmd (no RegWrite, no flag write).

Test Plan:
- Release reset; Instr=0xE2821005 (ADD R1,R2,#5) -> State 0,1,7,8,0. PCWrite=1 only in FETCH. ALUSrcB=01 in EXECUTEI. RegWrite=1 only in ALUWB.
- 0xE5910004 (LDR) -> 0,1,2,3,4; AdrSrc=1 in MEMREAD; ResultSrc=01 & RegWrite=1 in MEMWB. 0xE5810004 (STR) -> RegSrc=10, MemWrite=1 for exactly one cycle in state 5.
- 0xE0500000 (SUBS) with ALUFlags=0100 in EXECUTER -> Flags=0100. Then 0x0A000002 (BEQ) -> ImmSrc=10, PCWrite=1 in BRANCH. 0x1A000002 (BNE) -> PCWrite=0 in BRANCH.
- With Z=1, 0x12811001 (ADDNE) -> 4 cycles, RegWrite=0 throughout, Flags unchanged.
- 0xEC000000 (Op=11), FETCH_ONLY_UNDEF=1 -> DECODE->FETCH, no enables. Reset pulled low during MEMWRITE -> MemWrite drops to 0 immediately, State=0.
- 0xE3500000 (CMP R0,#0), ALUFlags=0100 -> with CTRL_CMP_EN: ALUControl=001, Flags=0100, RegWrite=0. Without CTRL_CMP_EN: ALUControl=000, Flags unchanged.
